// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment driver: the hex font,
// segment bit positions and the brightness control width.
package seg7_pkg;

  localparam int BRIGHT_W = 4;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high segment patterns, bit 0 = a ... bit 6 = g, indexed by nibble.
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_mux_driver_if.sv
// Value/brightness input bundle and pin-level outputs of the display driver.
// master = the producer of values (and observer of the pins), slave = driver.
interface seg7_mux_driver_if #(
  parameter int DIGITS = 4
);
  import seg7_pkg::*;

  logic [4*DIGITS-1:0] VALUE;
  logic [DIGITS-1:0]   DP;
  logic                LOAD;
  logic [BRIGHT_W-1:0] BRIGHT;
  logic [7:0]          SEG;
  logic [DIGITS-1:0]   SEL;
  logic                PENDING;
  logic                FRAME;

  modport master (
    output VALUE, DP, LOAD, BRIGHT,
    input  SEG, SEL, PENDING, FRAME
  );

  modport slave (
    input  VALUE, DP, LOAD, BRIGHT,
    output SEG, SEL, PENDING, FRAME
  );

endinterface

// File: rtl/seg7_font.sv
// Combinational hex-to-segment decode; output is always active-high, the
// caller applies any pin polarity.
module seg7_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  // Look up the glyph and attach the decimal point.
  always_comb begin
    seg               = '0;
    seg[SEG_G:SEG_A]  = FONT[nibble];
    seg[SEG_DP]       = dp;
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Multiplexed seven-segment driver with PWM brightness and tear-free value
// updates applied only at frame boundaries.
// Optional feature: define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             CLKIN,
  input  logic             RESET,
  seg7_mux_driver_if.slave bus
);

  // The slot is split into 16 brightness phases of DIV cycles each, so the
  // phase is a counter of its own rather than a divide of the slot count.
  localparam int DIV   = PRESCALE / 16;
  localparam int SUB_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic             INV      = (ACTIVE_LOW != 0);

  logic [SUB_W-1:0]    sub_reg;
  logic [3:0]          phase_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [4*DIGITS-1:0] disp_val_reg, stg_val_reg;
  logic [DIGITS-1:0]   disp_dp_reg, stg_dp_reg;
  logic                pend_reg, frame_reg;
  logic [7:0]          seg_reg, seg_next;
  logic [DIGITS-1:0]   sel_reg, sel_next;
  logic                slot_end, frame_end, enable, blank;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic [7:0]          font_seg;
  logic [DIGITS-1:0]   lz_blank;

  assign slot_end  = (sub_reg == SUB_LAST) && (phase_reg == 4'hF);
  assign frame_end = slot_end && (idx_reg == IDX_LAST);

  // Slot position (sub-phase, phase) and digit index.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      sub_reg   <= '0;
      phase_reg <= '0;
      idx_reg   <= '0;
    end else begin
      if (sub_reg == SUB_LAST) begin
        sub_reg   <= '0;
        phase_reg <= phase_reg + 4'd1;
      end else begin
        sub_reg <= sub_reg + SUB_W'(1);
      end
      if (slot_end)
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
    end
  end

  // Staging/display handshake; a load on the boundary bypasses staging.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      disp_val_reg <= '0;
      disp_dp_reg  <= '0;
      stg_val_reg  <= '0;
      stg_dp_reg   <= '0;
      pend_reg     <= 1'b0;
      frame_reg    <= 1'b0;
    end else begin
      frame_reg <= frame_end;
      if (bus.LOAD && frame_end) begin
        disp_val_reg <= bus.VALUE;
        disp_dp_reg  <= bus.DP;
        pend_reg     <= 1'b0;
      end else if (bus.LOAD) begin
        stg_val_reg <= bus.VALUE;
        stg_dp_reg  <= bus.DP;
        pend_reg    <= 1'b1;
      end else if (frame_end && pend_reg) begin
        disp_val_reg <= stg_val_reg;
        disp_dp_reg  <= stg_dp_reg;
        pend_reg     <= 1'b0;
      end
    end
  end

  assign cur_nib = disp_val_reg[{idx_reg, 2'b00} +: 4];
  assign cur_dp  = disp_dp_reg[idx_reg];
  assign enable  = (phase_reg <= bus.BRIGHT);

  seg7_font u_font (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (font_seg)
  );

`ifdef SEG7_LZ_BLANK_EN
  // lz_blank[i]: digit i and every digit above it are zero with no point.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_keep
        assign lz_blank[gi] = 1'b0;
      end else if (gi == DIGITS - 1) begin : g_top
        assign lz_blank[gi] = (disp_val_reg[4*gi +: 4] == 4'h0) && !disp_dp_reg[gi];
      end else begin : g_mid
        assign lz_blank[gi] = lz_blank[gi+1] &&
                              (disp_val_reg[4*gi +: 4] == 4'h0) && !disp_dp_reg[gi];
      end
    end
  endgenerate
  assign blank = lz_blank[idx_reg];
`else
  assign lz_blank = '0;
  assign blank    = lz_blank[0];
`endif

  // Active-high pin image for this cycle, then polarity applied.
  always_comb begin
    seg_next = '0;
    sel_next = '0;
    if (enable) begin
      sel_next = DIGITS'(1) << idx_reg;
      if (!blank)
        seg_next = font_seg;
    end
    seg_next = seg_next ^ {8{INV}};
    sel_next = sel_next ^ {DIGITS{INV}};
  end

  // Registered pins; reset leaves everything dark.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      seg_reg <= {8{INV}};
      sel_reg <= {DIGITS{INV}};
    end else begin
      seg_reg <= seg_next;
      sel_reg <= sel_next;
    end
  end

  assign bus.SEG     = seg_reg;
  assign bus.SEL     = sel_reg;
  assign bus.PENDING = pend_reg;
  assign bus.FRAME   = frame_reg;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Self-checking bench for seg7_mux_driver (DIGITS=4, PRESCALE=16, active-low).
// Honours SEG7_LZ_BLANK_EN when the build defines it.
module tb_seg7_mux_driver;

  localparam int D = 4;
  localparam int P = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_mux_driver_if #(.DIGITS(D)) bus ();

  seg7_mux_driver #(
    .DIGITS     (D),
    .PRESCALE   (P),
    .ACTIVE_LOW (1)
  ) dut (
    .CLKIN (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: cycles since reset release plus the two registers.
  logic [6:0]  font_tab [16];
  int          t_next, t_proc;
  logic [15:0] m_disp, m_stg;
  logic [3:0]  m_disp_dp, m_stg_dp;
  logic        m_pend;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_sel;
  logic        exp_pend, exp_frame;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0d", name, act, req, t_proc);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented at it.
  task automatic model_step();
    int cnt, idx, phase;
    logic [3:0] nib;
    logic dpb, blank, en, boundary;
    if (rst) begin
      exp_seg = 8'hFF; exp_sel = 4'hF; exp_pend = 1'b0; exp_frame = 1'b0;
      m_disp = '0; m_stg = '0; m_disp_dp = '0; m_stg_dp = '0; m_pend = 1'b0;
      t_next = 0; t_proc = -1;
    end else begin
      cnt      = t_next % P;
      idx      = (t_next / P) % D;
      phase    = cnt * 16 / P;
      boundary = (t_next % (D * P)) == (D * P - 1);
      en       = phase <= int'(bus.BRIGHT);
      nib      = m_disp[4*idx +: 4];
      dpb      = m_disp_dp[idx];
      blank    = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
      blank = (idx != 0);
      for (int k = D - 1; k >= idx && k > 0; k--)
        if (m_disp[4*k +: 4] != 4'h0 || m_disp_dp[k]) blank = 1'b0;
`endif
      exp_sel   = en ? ~(4'b0001 << idx) : 4'hF;
      exp_seg   = (en && !blank) ? ~{dpb, font_tab[nib]} : 8'hFF;
      exp_frame = boundary;
      if (bus.LOAD && boundary) begin
        m_disp = bus.VALUE; m_disp_dp = bus.DP; m_pend = 1'b0;
      end else if (bus.LOAD) begin
        m_stg = bus.VALUE; m_stg_dp = bus.DP; m_pend = 1'b1;
      end else if (boundary && m_pend) begin
        m_disp = m_stg; m_disp_dp = m_stg_dp; m_pend = 1'b0;
      end
      exp_pend = m_pend;
      t_proc   = t_next;
      t_next++;
    end
  endtask

  // One clock: model at the edge, compare every output on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("seg",     bus.SEG,     exp_seg);
    chk("sel",     bus.SEL,     exp_sel);
    chk("pending", bus.PENDING, exp_pend);
    chk("frame",   bus.FRAME,   exp_frame);
  endtask

  task automatic run_to(input int k);
    for (int n = 0; n < 2000 && t_proc < k; n++) cycle();
    if (t_proc < k) begin
      failures++;
      $display("FAIL run_to actual=%0d required=%0d", t_proc, k);
    end
  endtask

  task automatic load_at(input int k, input logic [15:0] v, input logic [3:0] d);
    run_to(k - 1);
    bus.LOAD = 1'b1; bus.VALUE = v; bus.DP = d;
    cycle();
    bus.LOAD = 1'b0;
  endtask

  initial begin
    font_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    t_next = 0; t_proc = -1;
    m_disp = '0; m_stg = '0; m_disp_dp = '0; m_stg_dp = '0; m_pend = 1'b0;
    rst = 1'b1; bus.LOAD = 1'b0; bus.VALUE = '0; bus.DP = '0; bus.BRIGHT = 4'd15;

    // Reset state
    repeat (5) cycle();
    chk("rst_seg", bus.SEG, 8'hFF);
    chk("rst_sel", bus.SEL, 4'hF);
    chk("rst_pending", bus.PENDING, 1'b0);
    chk("rst_frame", bus.FRAME, 1'b0);
    rst = 1'b0;
    cycle();
    chk("first_sel", bus.SEL, 4'hE);
    chk("first_seg", bus.SEG, 8'hC0);

    // Staged load of 1234 applied at the first boundary
    load_at(3, 16'h1234, 4'h0);
    chk("pend_set", bus.PENDING, 1'b1);
    run_to(62);
    chk("pend_hold", bus.PENDING, 1'b1);
    run_to(63);
    chk("pend_clr", bus.PENDING, 1'b0);
    chk("frame_pulse", bus.FRAME, 1'b1);
    run_to(64);
    chk("d0_sel", bus.SEL, 4'hE);
    chk("d0_seg", bus.SEG, 8'h99);
    chk("frame_low", bus.FRAME, 1'b0);
    run_to(80);
    chk("d1_sel", bus.SEL, 4'hD);
    chk("d1_seg", bus.SEG, 8'hB0);
    run_to(112);
    chk("d3_sel", bus.SEL, 4'h7);
    chk("d3_seg", bus.SEG, 8'hF9);
    run_to(127);
    chk("frame_pulse2", bus.FRAME, 1'b1);

    // Brightness 3 then 0
    run_to(128);
    bus.BRIGHT = 4'd3;
    run_to(131);
    chk("b3_on", bus.SEL, 4'hE);
    run_to(132);
    chk("b3_off_sel", bus.SEL, 4'hF);
    chk("b3_off_seg", bus.SEG, 8'hFF);
    run_to(143);
    bus.BRIGHT = 4'd0;
    run_to(144);
    chk("b0_on", bus.SEL, 4'hD);
    run_to(145);
    chk("b0_off", bus.SEL, 4'hF);
    bus.BRIGHT = 4'd15;

    // Last load wins; load on the boundary goes straight to display
    load_at(150, 16'hAAAA, 4'h0);
    load_at(160, 16'h5555, 4'h0);
    run_to(192);
    chk("last_wins", bus.SEG, 8'h92);
    load_at(255, 16'h0001, 4'h0);
    chk("bnd_pend", bus.PENDING, 1'b0);
    run_to(256);
    chk("bnd_disp", bus.SEG, 8'hF9);

    // Mid-frame reset discards a pending value
    load_at(260, 16'h9999, 4'hF);
    chk("pend_before_rst", bus.PENDING, 1'b1);
    run_to(270);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_pend", bus.PENDING, 1'b0);
    chk("mid_rst_sel", bus.SEL, 4'hF);
    run_to(64);
    chk("post_rst_d0", bus.SEG, 8'hC0);
    run_to(112);
`ifdef SEG7_LZ_BLANK_EN
    chk("post_rst_d3", bus.SEG, 8'hFF);
`else
    chk("post_rst_d3", bus.SEG, 8'hC0);
`endif

`ifdef SEG7_LZ_BLANK_EN
    // Leading-zero blanking
    load_at(130, 16'h0050, 4'h0);
    run_to(192);
    chk("lz_d0", bus.SEG, 8'hC0);
    run_to(208);
    chk("lz_d1", bus.SEG, 8'h92);
    run_to(224);
    chk("lz_d2", bus.SEG, 8'hFF);
    run_to(240);
    chk("lz_d3", bus.SEG, 8'hFF);
    load_at(245, 16'h0050, 4'b1000);
    run_to(304);
    chk("lz_dp3", bus.SEG, 8'h40);
`endif

    // Randomised traffic checked against the model every cycle
    for (int n = 0; n < 3000; n++) begin
      bus.LOAD  = ($urandom % 12) == 0;
      bus.VALUE = 16'($urandom);
      bus.DP    = 4'($urandom);
      if (($urandom % 40) == 0) bus.BRIGHT = 4'($urandom);
      rst = ($urandom % 600) == 0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_mux_driver.md
# seg7_mux_driver

Parametrised multiplexed seven-segment display driver: the next generation of the board's 4-digit LED display logic. It drives DIGITS common-select digits from a packed hex value, with per-digit decimal points and PWM brightness. A LOAD handshake stages new values and applies them only at frame boundaries, so displayed values never tear. It sits between any counter or datapath producing a hex value and the board's SEG/SEL pins.

## Interface
- DIGITS, 4: number of digits multiplexed (1..8).
- PRESCALE, 50000: CLKIN cycles per digit slot; must be a multiple of 16, minimum 16.
- ACTIVE_LOW, 1: 1 = SEG and SEL pins are active-low (board default); 0 = active-high.

Ports:
- CLKIN  in  1  system clock; the block's only clock.
- RESET  in  1  synchronous, active-high reset.
- VALUE  in  4*DIGITS  hex nibbles; nibble i (VALUE[4i+3:4i]) goes to digit i; digit 0 is rightmost.
- DP  in  DIGITS  decimal point per digit.
- LOAD  in  1  single-cycle strobe that captures VALUE and DP.
- BRIGHT  in  4  brightness; digit lit for (BRIGHT+1)/16 of each slot; sampled every cycle.
- SEG  out  8  SEG[7] = DP, SEG[6:0] = segments g..a; registered.
- SEL  out  DIGITS  one-hot digit select; registered.
- PENDING  out  1  staged value waiting for a frame boundary.
- FRAME  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- Slot counter cnt runs 0..PRESCALE-1. Digit index idx advances when cnt = PRESCALE-1 and wraps from DIGITS-1 to 0.
- Frame boundary is the cycle with cnt = PRESCALE-1 and idx = DIGITS-1. FRAME is registered and is high during the cycle after that boundary.
- Brightness phase = cnt / (PRESCALE/16). The selected digit is enabled while phase ≤ BRIGHT. When disabled, SEL and SEG are all inactive.
- Font: standard hex 0-F, abcdefg. For example, 0 = 7'h3F and 4 = 7'h66 active-high. When ACTIVE_LOW = 1, SEG and SEL are inverted.
- Handshake:
  - LOAD copies VALUE and DP into the staging register and sets PENDING.
  - At a frame boundary with PENDING set, staging is copied to the display register and PENDING clears.
  - A LOAD while PENDING is already set overwrites staging; the last LOAD wins.
  - A LOAD on the boundary cycle writes directly to the display register, and PENDING is 0 on the next cycle.
- Reset values:
  - cnt = 0, idx = 0.
  - Display and staging registers = 0.
  - PENDING = 0, FRAME = 0.
  - SEL and SEG all inactive (8'hFF and all-ones SEL when ACTIVE_LOW).
- RESET asserted mid-frame aborts the frame and discards any pending value. Reset has priority over LOAD.

## Timing
- Output latency: SEG and SEL reflect (cnt, idx) of the previous cycle.
- The first cycle after RESET deasserts has cnt = 0. Digit 0 is visible on the following cycle.
- Frame period = DIGITS × PRESCALE cycles.
- Worst-case latency from LOAD to display = DIGITS × PRESCALE + 1 cycles. Best case = 1 cycle (LOAD on the boundary cycle).
- Changes to BRIGHT take effect with 1-cycle latency.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero blanking.
  - Blanked: digits from DIGITS-1 downward whose nibble is 0 and whose DP is 0, stopping at the first digit that fails this test.
  - Blanked digits drive SEG inactive, but SEL still cycles normally.
  - Digit 0 is never blanked.
- SEG7_LZ_BLANK_EN undefined: every digit always shows its nibble; blanking logic is absent.

## Structure
- Package seg7_pkg holds:
  - the 16-entry font constant;
  - segment bit-index constants SEG_DP = 7 and SEG_A = 0..SEG_G = 6;
  - the BRIGHT width constant.
- Sub-module seg7_font: combinational nibble + dp → 8-bit active-high segment vector. The polarity inversion stays in the top level.
- The top level contains the counters, the staging/display registers with the handshake, the PWM compare, blanking, and the output registers.

## Test plan
Bench configuration: DIGITS = 4, PRESCALE = 16, ACTIVE_LOW = 1.
1. Hold RESET for 5 cycles → SEG = 8'hFF, SEL = 4'hF, PENDING = 0, FRAME = 0. Release → SEL = 4'hE two cycles later.
2. BRIGHT = 15, LOAD with VALUE = 16'h1234, DP = 0 → PENDING stays 1 until the boundary. Then in the next frame digit 0 shows SEG = 8'h99, digit 3 shows 8'hF9, and SEL steps E, D, B, 7 every 16 cycles. FRAME pulses every 64 cycles.
3. BRIGHT = 3 → each SEL value is active for 4 of 16 cycles and is 4'hF for the other 12. BRIGHT = 0 → active for 1 cycle per slot.
4. LOAD 16'hAAAA, then LOAD 16'h5555 before the boundary → only 5555 is ever displayed. A LOAD of 16'h0001 on the boundary cycle → displayed in the next frame with PENDING = 0.
5. RESET for one cycle mid-frame while PENDING = 1 → the display register becomes 0 and PENDING = 0. The next frame shows 0000 (or 0 on digit 0 only, with blanking enabled).
6. With SEG7_LZ_BLANK_EN defined, VALUE = 16'h0050, DP = 0 → digits 3 and 2 show SEG = 8'hFF, digit 1 shows 8'h92, digit 0 shows 8'hC0. With DP[3] = 1 → digit 3 shows 8'h40.
